leitor_jogadas: RTL

//   Consumer side of the 3-move memory. On start, snapshots the three stored
//   (coluna,linha) pairs, shows them one at a time on the board display, then

---
 rtl/leitor_jogadas.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/leitor_jogadas.sv
// Playback and check of the three stored moves: snapshot on start, show each move,
// then compare the player's three moves against the snapshot.
//   state   | meaning
//   OCIOSO  | idle, waiting for iniciar
//   CARREGA | one cycle, latch the three stored moves
//   EXIBE   | showing snapshot[indice]
//   PAUSA   | blank gap between shown moves
//   ESPERA  | waiting for the player's move number indice
//   ACERTO  | all three moves matched
//   ERRO    | a move mismatched
module leitor_jogadas #(
  parameter int TEMPO_EXIBICAO = 25,
  parameter int TEMPO_PAUSA    = 5,
  parameter int LARGURA_CONT   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] coluna1,
  input  logic [2:0] linha1,
  input  logic [2:0] coluna2,
  input  logic [2:0] linha2,
  input  logic [2:0] coluna3,
  input  logic [2:0] linha3,
  input  logic       jogadaValida,
  input  logic [2:0] colunaJogador,
  input  logic [2:0] linhaJogador,
  output logic [2:0] colunaExibida,
  output logic [2:0] linhaExibida,
  output logic       exibindo,
  output logic       aguardandoJogada,
  output logic [1:0] indice,
  output logic       acertou,
  output logic       errou
);

  typedef enum logic [2:0] {
    OCIOSO, CARREGA, EXIBE, PAUSA, ESPERA, ACERTO, ERRO
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] C_EXIBE = LARGURA_CONT'(TEMPO_EXIBICAO - 1);
  localparam logic [LARGURA_CONT-1:0] C_PAUSA = LARGURA_CONT'(TEMPO_PAUSA - 1);

  estado_t                 r_estado, w_estado_nxt;
  logic [1:0]              r_indice, w_indice_nxt;
  logic [LARGURA_CONT-1:0] r_cont, w_cont_nxt;
  logic [2:0][2:0]         r_snap_col, r_snap_lin, w_snap_col_nxt, w_snap_lin_nxt;
  logic [2:0]              w_col_sel, w_lin_sel, w_col_esp, w_lin_esp;
  logic                    w_exibe_nxt;

  function automatic logic [2:0] seleciona(input logic [2:0][2:0] v, input logic [1:0] i);
    case (i)
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return v[0];
    endcase
  endfunction

  assign w_col_esp = seleciona(r_snap_col, r_indice);
  assign w_lin_esp = seleciona(r_snap_lin, r_indice);

  always_comb begin
    w_estado_nxt   = r_estado;
    w_indice_nxt   = r_indice;
    w_cont_nxt     = r_cont;
    w_snap_col_nxt = r_snap_col;
    w_snap_lin_nxt = r_snap_lin;
    case (r_estado)
      OCIOSO, ACERTO, ERRO: begin
        if (iniciar) begin
          w_estado_nxt = CARREGA;
          w_indice_nxt = 2'd0;
        end
      end
      CARREGA: begin
        w_snap_col_nxt = {coluna3, coluna2, coluna1};
        w_snap_lin_nxt = {linha3, linha2, linha1};
        w_indice_nxt   = 2'd0;
        w_cont_nxt     = C_EXIBE;
        w_estado_nxt   = EXIBE;
      end
      EXIBE: begin
        if (r_cont == '0) begin
          if (r_indice == 2'd2) begin
            w_estado_nxt = ESPERA;
            w_indice_nxt = 2'd0;
          end else begin
            w_estado_nxt = PAUSA;
            w_cont_nxt   = C_PAUSA;
          end
        end else begin
          w_cont_nxt = r_cont - 1'b1;
        end
      end
      PAUSA: begin
        if (r_cont == '0) begin
          w_estado_nxt = EXIBE;
          w_indice_nxt = r_indice + 2'd1;
          w_cont_nxt   = C_EXIBE;
        end else begin
          w_cont_nxt = r_cont - 1'b1;
        end
      end
      ESPERA: begin
        if (jogadaValida) begin
          if (colunaJogador == w_col_esp && linhaJogador == w_lin_esp) begin
            if (r_indice == 2'd2) w_estado_nxt = ACERTO;
            else                  w_indice_nxt = r_indice + 2'd1;
          end else begin
            w_estado_nxt = ERRO;
          end
        end
      end
      default: w_estado_nxt = OCIOSO;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  assign w_exibe_nxt = (w_estado_nxt == EXIBE);
  assign w_col_sel   = seleciona(w_snap_col_nxt, w_indice_nxt);
  assign w_lin_sel   = seleciona(w_snap_lin_nxt, w_indice_nxt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado         <= OCIOSO;
      r_indice         <= 2'd0;
      r_cont           <= '0;
      r_snap_col       <= '0;
      r_snap_lin       <= '0;
      colunaExibida    <= 3'd0;
      linhaExibida     <= 3'd0;
      exibindo         <= 1'b0;
      aguardandoJogada <= 1'b0;
      indice           <= 2'd0;
      acertou          <= 1'b0;
      errou            <= 1'b0;
    end else begin
      r_estado         <= w_estado_nxt;
      r_indice         <= w_indice_nxt;
      r_cont           <= w_cont_nxt;
      r_snap_col       <= w_snap_col_nxt;
      r_snap_lin       <= w_snap_lin_nxt;
      colunaExibida    <= w_exibe_nxt ? w_col_sel : 3'd0;
      linhaExibida     <= w_exibe_nxt ? w_lin_sel : 3'd0;
      exibindo         <= w_exibe_nxt;
      aguardandoJogada <= (w_estado_nxt == ESPERA);
      indice           <= w_indice_nxt;
      acertou          <= (w_estado_nxt == ACERTO);
      errou            <= (w_estado_nxt == ERRO);
    end
  end

endmodule
